// File: rtl/uart_tx_rx.sv
// 8N1 UART transmitter and receiver sharing one clock; the two halves run independently.
// TX outputs are registered; RX samples mid-bit after a 2-flop synchronizer.
module uart_tx_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [7:0] i_data_byte,
  input  logic       i_data_avail,
  output logic       o_Tx,
  output logic       o_busy,
  output logic       o_done,
  input  logic       i_Rx,
  output logic [7:0] o_data_byte,
  output logic       o_data_avail
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;

  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_data, tx_data_n;
  logic          tx_n, busy_n, done_n;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_data  <= '0;
      o_Tx     <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_data  <= tx_data_n;
      o_Tx     <= tx_n;
      o_busy   <= busy_n;
      o_done   <= done_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_data_n  = tx_data;
    tx_n       = o_Tx;
    busy_n     = o_busy;
    done_n     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (i_data_avail) begin
          tx_data_n  = i_data_byte;
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_DATA;
          tx_n       = tx_data[0];
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_DATA: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            tx_idx_n   = '0;
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
          end else begin
            tx_idx_n = tx_idx + 3'd1;
            tx_n     = tx_data[tx_idx + 3'd1];
          end
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_STOP: begin
        // o_done rises together with the fall of o_busy
        if (tx_cnt == LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_DONE;
          done_n     = 1'b1;
          busy_n     = 1'b0;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_DONE:  tx_state_n = TX_IDLE;
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP} rx_state_t;

  rx_state_t     rx_state, rx_state_n;
  logic [1:0]    rx_sync;
  logic          rx_s;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_shift, rx_shift_n, byte_n;
  logic          avail_n;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync      <= 2'b11;
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      o_data_byte  <= '0;
      o_data_avail <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[0], i_Rx};
      rx_state     <= rx_state_n;
      rx_cnt       <= rx_cnt_n;
      rx_idx       <= rx_idx_n;
      rx_shift     <= rx_shift_n;
      o_data_byte  <= byte_n;
      o_data_avail <= avail_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    byte_n     = o_data_byte;
    avail_n    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (!rx_s) rx_state_n = RX_START;
      end
      RX_START: begin
        // re-check at the middle of the start bit to reject glitches
        if (rx_cnt == HALF) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n           = '0;
          rx_shift_n[rx_idx] = rx_s;
          if (rx_idx == 3'd7) begin
            rx_idx_n   = '0;
            rx_state_n = RX_STOP;
          end else rx_idx_n = rx_idx + 3'd1;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_CLEANUP;
          if (rx_s) begin
            byte_n  = rx_shift;
            avail_n = 1'b1;
          end
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_CLEANUP: rx_state_n = RX_IDLE;
      default:    rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_rx.sv
// Directed bench for uart_tx_rx: loopback frames, bench-driven RX frames, glitch, framing error, reset.
// Received bytes are matched against a queue filled when each frame is launched.
module tb_uart_tx_rx;
  localparam int N = 434;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data_byte = 8'h00;
  logic       i_data_avail = 1'b0;
  logic       i_Rx;
  logic       o_Tx, o_busy, o_done;
  logic [7:0] o_data_byte;
  logic       o_data_avail;

  logic loop = 1'b1;
  logic rx_drv = 1'b1;
  assign i_Rx = loop ? o_Tx : rx_drv;

  int total = 0;
  int bad = 0;
  int avail_cnt = 0;
  logic [7:0] sb[$];

  always #10 clk_50M = ~clk_50M;

  uart_tx_rx #(.CLKS_PER_BIT(N)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .i_data_byte(i_data_byte), .i_data_avail(i_data_avail),
    .o_Tx(o_Tx), .o_busy(o_busy), .o_done(o_done),
    .i_Rx(i_Rx), .o_data_byte(o_data_byte), .o_data_avail(o_data_avail)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one TX request and check every bit boundary, busy and done on the line.
  task automatic tx_frame(input logic [7:0] b, input bit mid_change);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    @(negedge clk_50M);
    i_data_byte  = b;
    i_data_avail = 1'b1;
    sb.push_back(b);
    for (int c = 0; c <= 10*N + 3; c++) begin
      @(negedge clk_50M);
      if (c == 0) i_data_avail = 1'b0;
      if (mid_change && c == 3*N) begin
        i_data_byte  = 8'hFF;
        i_data_avail = 1'b1;
      end
      if (mid_change && c == 3*N + 1) i_data_avail = 1'b0;
      if (c < 10*N) begin
        if (c % N == 0 || c % N == N-1) check("tx_bit", o_Tx, f[c/N]);
        check("busy_in_frame", o_busy, 1);
        check("done_in_frame", o_done, 0);
      end else begin
        check("tx_idle_after", o_Tx, 1);
        check("busy_after", o_busy, 0);
        check("done_pulse", o_done, c == 10*N);
      end
    end
  endtask

  // Drive an 8N1 frame onto i_Rx directly, with a chosen stop bit.
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) sb.push_back(b);
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (N) @(negedge clk_50M);
    end
    rx_drv = 1'b1;
    repeat (2*N) @(negedge clk_50M);
  endtask

  initial begin
    repeat (3) @(negedge clk_50M);
    check("rst_tx", o_Tx, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_byte", o_data_byte, 8'h00);
    check("rst_avail", o_data_avail, 0);
    rst_n = 1'b1;

    fork
      forever begin
        @(negedge clk_50M);
        if (rst_n && o_data_avail) begin
          avail_cnt++;
          if (sb.size() == 0) check("rx_unexpected_avail", o_data_avail, 0);
          else check("rx_byte", o_data_byte, sb.pop_front());
        end
      end
    join_none

    repeat (5) @(negedge clk_50M);
    tx_frame(8'h19, 1'b0);
    tx_frame(8'h63, 1'b0);
    tx_frame(8'hC3, 1'b1);
    check("loop_sb_empty", sb.size(), 0);
    check("loop_avail_cnt", avail_cnt, 3);

    loop = 1'b0;
    repeat (10) @(negedge clk_50M);
    rx_drv = 1'b0;
    repeat (100) @(negedge clk_50M);
    rx_drv = 1'b1;
    repeat (2*N) @(negedge clk_50M);
    check("glitch_no_avail", avail_cnt, 3);

    rx_frame(8'hA5, 1'b0);
    check("framing_no_avail", avail_cnt, 3);
    check("framing_byte_kept", o_data_byte, 8'hC3);
    rx_frame(8'h3C, 1'b1);
    check("after_err_avail", avail_cnt, 4);
    check("after_err_byte", o_data_byte, 8'h3C);

    loop = 1'b1;
    @(negedge clk_50M);
    i_data_byte  = 8'h77;
    i_data_avail = 1'b1;
    @(negedge clk_50M);
    i_data_avail = 1'b0;
    repeat (3*N) @(negedge clk_50M);
    check("pre_rst_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", o_Tx, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_done, 0);
    check("mid_rst_avail", o_data_avail, 0);
    check("mid_rst_byte", o_data_byte, 8'h00);
    repeat (5) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (2*N) @(negedge clk_50M);
    check("abort_no_avail", avail_cnt, 4);
    check("abort_no_done", o_done, 0);

    tx_frame(8'h55, 1'b0);
    repeat (N) @(negedge clk_50M);
    check("final_sb_empty", sb.size(), 0);
    check("final_avail_cnt", avail_cnt, 5);
    check("final_byte", o_data_byte, 8'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
